// File: rtl/uart_rx_word.sv
// Packs four UART byte strobes little-endian into a 32-bit word with an auto-incrementing
// address, offered over valid/ready; an inter-byte timeout drops partial words.
module uart_rx_word #(
  parameter int unsigned CLOCKS_PER_BAUD = 434,
  parameter int unsigned TIMEOUT_BAUDS   = 40,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned ADDR_STEP       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              addr_clear,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              overflow,
  output logic              timeout
);

  localparam int unsigned TIMEOUT_CLKS = CLOCKS_PER_BAUD * TIMEOUT_BAUDS;
  localparam int unsigned TIMER_W      = $clog2(TIMEOUT_CLKS);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W-1:0]  STEP       = ADDR_W'(ADDR_STEP);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t             state, state_next;
  logic [1:0]         count, count_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [23:0]        held;
  logic [ADDR_W-1:0]  next_addr;
  logic               accept, word_done, expire, load, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    count_next = count;
    timer_next = timer;
    word_done  = 1'b0;
    expire     = 1'b0;
    accept     = rx_ready && !addr_clear;
    if (addr_clear) begin
      state_next = S_IDLE;
      count_next = '0;
      timer_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_ready) begin
            count_next = 2'd1;
            timer_next = '0;
            state_next = S_COLLECT;
          end
        end
        S_COLLECT: begin
          // A strobe on the expiry cycle takes precedence over the timeout.
          if (rx_ready) begin
            timer_next = '0;
            if (count == 2'd3) begin
              count_next = '0;
              state_next = S_IDLE;
              word_done  = 1'b1;
            end else begin
              count_next = count + 2'd1;
            end
          end else if (timer == TIMER_LAST) begin
            count_next = '0;
            timer_next = '0;
            state_next = S_IDLE;
            expire     = 1'b1;
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    load = word_done && (!word_valid || word_ready);
    drop = word_done && !load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      timer      <= '0;
      held       <= '0;
      next_addr  <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_addr  <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      count   <= count_next;
      timer   <= timer_next;
      timeout <= expire;
      if (accept) begin
        case (count)
          2'd0:    held[7:0]   <= rx_data;
          2'd1:    held[15:8]  <= rx_data;
          2'd2:    held[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (load) begin
        word_valid <= 1'b1;
        word_data  <= {rx_data, held};
        word_addr  <= next_addr;
        next_addr  <= next_addr + STEP;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
      if (addr_clear) begin
        next_addr <= '0;
        overflow  <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
